// File: rtl/text_console_if.sv
// text_console_if
//   Byte-stream handshake into the text console.
//   Signals:
//     in_data  [7:0] character byte
//     in_attr        attribute bit (becomes char_chr[8])
//     in_valid       producer has a byte on in_data/in_attr
//     in_ready       console can accept; transfer on valid && ready at clk edge
//   Modports:
//     master - byte producer (core or other source)
//     slave  - text_console
interface text_console_if;
  logic [7:0] in_data;
  logic       in_attr;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_attr,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_attr,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/text_console.sv
// text_console
//   Character-stream front end for the text-mode display. Accepts bytes over
//   the in_bus handshake, owns the cursor, interprets LF/CR/BS/FF, and drives
//   the display character write port. Line and screen clears are emitted as
//   one SP write per cycle.
//   Ports:
//     clk_sys            system clock
//     btn_rst_n          asynchronous active-low reset
//     in_bus (slave)     byte stream: in_data, in_attr, in_valid, in_ready
//     char_x/char_y      write position (registered)
//     char_chr           write character {attr, code} (registered)
//     char_str           one-cycle write strobe (registered)
//     cur_x/cur_y        current cursor position (registered)
module text_console #(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk_sys,
  input  logic                btn_rst_n,
  text_console_if.slave       in_bus,
  output logic [6:0]          char_x,
  output logic [5:0]          char_y,
  output logic [8:0]          char_chr,
  output logic                char_str,
  output logic [6:0]          cur_x,
  output logic [5:0]          cur_y
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_LINE   = 2'd1,
    ST_CLR_SCREEN = 2'd2
  } state_t;

  localparam logic [6:0] LAST_X    = 7'(COLS - 1);
  localparam logic [5:0] LAST_Y    = 6'(ROWS - 1);
  localparam logic [8:0] SP        = {1'b0, 8'h20};
  localparam state_t     RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLR_SCREEN : ST_IDLE;

  state_t     r_state,    w_state;
  logic [6:0] r_cur_x,    w_cur_x;
  logic [5:0] r_cur_y,    w_cur_y;
  logic [6:0] r_clr_x,    w_clr_x;
  logic [5:0] r_clr_y,    w_clr_y;
  // Set once the last clear write has been issued; the following cycle
  // returns to IDLE so in_ready rises only after the final strobe.
  logic       r_clr_done, w_clr_done;
  logic [6:0] r_char_x,   w_char_x;
  logic [5:0] r_char_y,   w_char_y;
  logic [8:0] r_char_chr, w_char_chr;
  logic       r_char_str, w_char_str;

  logic       w_ready;
  logic       w_accept;
  logic [5:0] w_next_row;

  assign w_ready         = (r_state == ST_IDLE);
  assign w_accept        = in_bus.in_valid & w_ready;
  assign in_bus.in_ready = w_ready;

  assign char_x   = r_char_x;
  assign char_y   = r_char_y;
  assign char_chr = r_char_chr;
  assign char_str = r_char_str;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;

  // Row that a line advance moves to, wrapping at the last row.
  always_comb begin
    w_next_row = r_cur_y + 6'd1;
    if (r_cur_y == LAST_Y) begin
      w_next_row = 6'd0;
    end else begin
      w_next_row = r_cur_y + 6'd1;
    end
  end

  // Next-state, cursor, clear counters and write-port values.
  always_comb begin
    w_state    = r_state;
    w_cur_x    = r_cur_x;
    w_cur_y    = r_cur_y;
    w_clr_x    = r_clr_x;
    w_clr_y    = r_clr_y;
    w_clr_done = r_clr_done;
    w_char_x   = r_char_x;
    w_char_y   = r_char_y;
    w_char_chr = r_char_chr;
    w_char_str = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (in_bus.in_data)
            8'h0A: begin
              // LF has no own write, so the first clear write (x=0) is
              // issued right away and the counter resumes at x=1.
              w_cur_x    = 7'd0;
              w_cur_y    = w_next_row;
              w_char_x   = 7'd0;
              w_char_y   = w_next_row;
              w_char_chr = SP;
              w_char_str = 1'b1;
              w_clr_x    = 7'd1;
              w_clr_done = 1'b0;
              w_state    = ST_CLR_LINE;
            end
            8'h0D: begin
              w_cur_x = 7'd0;
            end
            8'h08: begin
              if (r_cur_x != 7'd0) begin
                w_cur_x    = r_cur_x - 7'd1;
                w_char_x   = r_cur_x - 7'd1;
                w_char_y   = r_cur_y;
                w_char_chr = SP;
                w_char_str = 1'b1;
              end else begin
                w_cur_x = r_cur_x;
              end
            end
            8'h0C: begin
              // FF: home the cursor and issue the (0,0) clear write now.
              w_cur_x    = 7'd0;
              w_cur_y    = 6'd0;
              w_char_x   = 7'd0;
              w_char_y   = 6'd0;
              w_char_chr = SP;
              w_char_str = 1'b1;
              w_clr_x    = 7'd1;
              w_clr_y    = 6'd0;
              w_clr_done = 1'b0;
              w_state    = ST_CLR_SCREEN;
            end
            default: begin
              if ((in_bus.in_data >= 8'h20) && (in_bus.in_data <= 8'h7E)) begin
                w_char_x   = r_cur_x;
                w_char_y   = r_cur_y;
                w_char_chr = {in_bus.in_attr, in_bus.in_data};
                w_char_str = 1'b1;
                if (r_cur_x == LAST_X) begin
                  // Own write goes out now; the line clear starts next cycle.
                  w_cur_x    = 7'd0;
                  w_cur_y    = w_next_row;
                  w_clr_x    = 7'd0;
                  w_clr_done = 1'b0;
                  w_state    = ST_CLR_LINE;
                end else begin
                  w_cur_x = r_cur_x + 7'd1;
                end
              end else begin
                // Unsupported byte: consumed without effect.
                w_cur_x = r_cur_x;
              end
            end
          endcase
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_CLR_LINE: begin
        if (r_clr_done) begin
          w_clr_done = 1'b0;
          w_clr_x    = 7'd0;
          w_state    = ST_IDLE;
        end else begin
          w_char_x   = r_clr_x;
          w_char_y   = r_cur_y;
          w_char_chr = SP;
          w_char_str = 1'b1;
          if (r_clr_x == LAST_X) begin
            w_clr_x    = 7'd0;
            w_clr_done = 1'b1;
          end else begin
            w_clr_x = r_clr_x + 7'd1;
          end
        end
      end

      ST_CLR_SCREEN: begin
        if (r_clr_done) begin
          w_clr_done = 1'b0;
          w_clr_x    = 7'd0;
          w_clr_y    = 6'd0;
          w_cur_x    = 7'd0;
          w_cur_y    = 6'd0;
          w_state    = ST_IDLE;
        end else begin
          w_char_x   = r_clr_x;
          w_char_y   = r_clr_y;
          w_char_chr = SP;
          w_char_str = 1'b1;
          if (r_clr_x == LAST_X) begin
            w_clr_x = 7'd0;
            if (r_clr_y == LAST_Y) begin
              w_clr_y    = 6'd0;
              w_clr_done = 1'b1;
            end else begin
              w_clr_y = r_clr_y + 6'd1;
            end
          end else begin
            w_clr_x = r_clr_x + 7'd1;
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State, cursor, clear counters and registered write-port outputs.
  always_ff @(posedge clk_sys or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      r_state    <= RST_STATE;
      r_cur_x    <= 7'd0;
      r_cur_y    <= 6'd0;
      r_clr_x    <= 7'd0;
      r_clr_y    <= 6'd0;
      r_clr_done <= 1'b0;
      r_char_x   <= 7'd0;
      r_char_y   <= 6'd0;
      r_char_chr <= 9'd0;
      r_char_str <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cur_x    <= w_cur_x;
      r_cur_y    <= w_cur_y;
      r_clr_x    <= w_clr_x;
      r_clr_y    <= w_clr_y;
      r_clr_done <= w_clr_done;
      r_char_x   <= w_char_x;
      r_char_y   <= w_char_y;
      r_char_chr <= w_char_chr;
      r_char_str <= w_char_str;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// tb_text_console
//   Directed self-checking bench for text_console (80x60, clear on reset).
module tb_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic       clk_sys   = 1'b0;
  logic       btn_rst_n = 1'b0;
  logic [6:0] char_x;
  logic [5:0] char_y;
  logic [8:0] char_chr;
  logic       char_str;
  logic [6:0] cur_x;
  logic [5:0] cur_y;

  int n_checks = 0;
  int n_errors = 0;

  // 100 MHz system clock.
  always #5 clk_sys = ~clk_sys;

  text_console_if in_bus ();

  text_console #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk_sys   (clk_sys),
    .btn_rst_n (btn_rst_n),
    .in_bus    (in_bus),
    .char_x    (char_x),
    .char_y    (char_y),
    .char_chr  (char_chr),
    .char_str  (char_str),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic a);
    in_bus.in_data  = d;
    in_bus.in_attr  = a;
    in_bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic a);
    drive(d, a);
    tick();
    in_bus.in_valid = 1'b0;
  endtask

  // n consecutive SP strobes starting at (x0,y0), row-major, in_ready low.
  task automatic expect_writes(input string tag, input int n, input int x0, input int y0);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      int ex;
      int ey;
      ex = (x0 + i) % COLS;
      ey = y0 + (x0 + i) / COLS;
      if (char_str !== 1'b1 || char_chr !== 9'h020 || char_x !== 7'(ex) ||
          char_y !== 6'(ey) || in_bus.in_ready !== 1'b0) begin
        bad++;
      end
      tick();
    end
    check(tag, bad, 0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int cnt;
    cnt = 0;
    while (in_bus.in_ready !== 1'b1 && cnt < bound) begin
      tick();
      cnt++;
    end
    check(tag, {31'd0, in_bus.in_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    logic [7:0] c;

    in_bus.in_valid = 1'b0;
    in_bus.in_data  = 8'h00;
    in_bus.in_attr  = 1'b0;

    // Reset values while held in reset.
    #22;
    check("rst_str", {31'd0, char_str}, 32'd0);
    check("rst_xy", {19'd0, char_y, char_x}, 32'd0);
    check("rst_chr", {23'd0, char_chr}, 32'd0);
    check("rst_cur", {19'd0, cur_y, cur_x}, 32'd0);
    check("rst_ready", {31'd0, in_bus.in_ready}, 32'd0);

    // Release; first edge after release issues the (0,0) clear write.
    @(posedge clk_sys);
    #1;
    btn_rst_n = 1'b1;
    tick();
    expect_writes("rst_clear", ROWS * COLS, 0, 0);
    check("rst_clear_end_str", {31'd0, char_str}, 32'd0);
    check("rst_clear_ready", {31'd0, in_bus.in_ready}, 32'd1);
    check("rst_clear_cur", {19'd0, cur_y, cur_x}, 32'd0);

    // "AB" back-to-back with attr=1.
    drive(8'h41, 1'b1);
    tick();
    check("a_chr", {23'd0, char_chr}, 32'h141);
    check("a_str", {31'd0, char_str}, 32'd1);
    check("a_xy", {19'd0, char_y, char_x}, 32'd0);
    check("a_ready", {31'd0, in_bus.in_ready}, 32'd1);
    drive(8'h42, 1'b1);
    tick();
    in_bus.in_valid = 1'b0;
    check("b_chr", {23'd0, char_chr}, 32'h142);
    check("b_xy", {19'd0, char_y, char_x}, {19'd0, 6'd0, 7'd1});
    check("b_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd0, 7'd2});
    check("b_ready", {31'd0, in_bus.in_ready}, 32'd1);
    tick();
    check("idle_no_str", {31'd0, char_str}, 32'd0);
    check("idle_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd0, 7'd2});

    // CR back to column 0, no strobe.
    send(8'h0D, 1'b0);
    check("cr_str", {31'd0, char_str}, 32'd0);
    check("cr_cur", {19'd0, cur_y, cur_x}, 32'd0);

    // Fill row 0; the 80th byte wraps and clears row 1.
    bad = 0;
    for (int i = 0; i < COLS; i++) begin
      c = 8'h41 + 8'(i % 26);
      drive(c, 1'b0);
      tick();
      if (char_str !== 1'b1 || char_chr !== {1'b0, c} || char_x !== 7'(i) || char_y !== 6'd0) begin
        bad++;
      end
      if (i < COLS - 1 && in_bus.in_ready !== 1'b1) begin
        bad++;
      end
    end
    in_bus.in_valid = 1'b0;
    check("row0_writes", bad, 0);
    check("row0_last_x", {25'd0, char_x}, 32'd79);
    check("row0_wrap_ready", {31'd0, in_bus.in_ready}, 32'd0);
    check("row0_wrap_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd1, 7'd0});
    tick();
    expect_writes("row1_clear", COLS, 0, 1);
    check("row1_end_str", {31'd0, char_str}, 32'd0);
    check("row1_ready", {31'd0, in_bus.in_ready}, 32'd1);
    check("row1_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd1, 7'd0});

    // Walk down to row 59 with LFs.
    for (int r = 2; r < ROWS; r++) begin
      send(8'h0A, 1'b0);
      wait_idle("lf_walk_idle", 200);
    end
    check("walk_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd59, 7'd0});
    for (int i = 0; i < 5; i++) begin
      send(8'h30 + 8'(i), 1'b0);
    end
    check("row59_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd59, 7'd5});

    // LF on the last row wraps to row 0 and clears it; no character write.
    send(8'h0A, 1'b0);
    expect_writes("lf_wrap_clear", COLS, 0, 0);
    check("lf_wrap_str", {31'd0, char_str}, 32'd0);
    check("lf_wrap_ready", {31'd0, in_bus.in_ready}, 32'd1);
    check("lf_wrap_cur", {19'd0, cur_y, cur_x}, 32'd0);

    // Move to (3,2).
    send(8'h0A, 1'b0);
    wait_idle("lf_r1_idle", 200);
    send(8'h0A, 1'b0);
    wait_idle("lf_r2_idle", 200);
    for (int i = 0; i < 3; i++) begin
      send(8'h78, 1'b0);
    end
    check("pos32_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd3});

    // BS writes SP at the new column.
    send(8'h08, 1'b0);
    check("bs_str", {31'd0, char_str}, 32'd1);
    check("bs_chr", {23'd0, char_chr}, 32'h020);
    check("bs_xy", {19'd0, char_y, char_x}, {19'd0, 6'd2, 7'd2});
    check("bs_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd2});
    send(8'h0D, 1'b0);
    check("cr2_str", {31'd0, char_str}, 32'd0);
    check("cr2_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd0});
    send(8'h08, 1'b0);
    check("bs0_str", {31'd0, char_str}, 32'd0);
    check("bs0_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd0});
    send(8'h07, 1'b0);
    check("bel_str", {31'd0, char_str}, 32'd0);
    check("bel_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd0});
    check("bel_ready", {31'd0, in_bus.in_ready}, 32'd1);

    // FF mid-row; a byte held during the clear is not consumed.
    send(8'h51, 1'b1);
    check("q_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd2, 7'd1});
    send(8'h0C, 1'b0);
    check("ff_first_str", {31'd0, char_str}, 32'd1);
    check("ff_first_chr", {23'd0, char_chr}, 32'h020);
    check("ff_first_xy", {19'd0, char_y, char_x}, 32'd0);
    check("ff_cur", {19'd0, cur_y, cur_x}, 32'd0);
    check("ff_ready", {31'd0, in_bus.in_ready}, 32'd0);
    drive(8'h5A, 1'b0);
    tick();
    expect_writes("ff_clear_part", 10, 1, 0);
    check("ff_hold_cur", {19'd0, cur_y, cur_x}, 32'd0);

    // Asynchronous reset mid-clear.
    #2;
    btn_rst_n = 1'b0;
    #1;
    in_bus.in_valid = 1'b0;
    check("mid_rst_str", {31'd0, char_str}, 32'd0);
    check("mid_rst_xy", {19'd0, char_y, char_x}, 32'd0);
    check("mid_rst_chr", {23'd0, char_chr}, 32'd0);
    check("mid_rst_cur", {19'd0, cur_y, cur_x}, 32'd0);
    tick();
    tick();
    check("mid_rst_hold_str", {31'd0, char_str}, 32'd0);
    btn_rst_n = 1'b1;
    tick();
    expect_writes("restart_clear", ROWS * COLS, 0, 0);
    check("restart_ready", {31'd0, in_bus.in_ready}, 32'd1);
    check("restart_cur", {19'd0, cur_y, cur_x}, 32'd0);

    // Normal operation resumes.
    send(8'h5A, 1'b0);
    check("post_chr", {23'd0, char_chr}, 32'h05A);
    check("post_xy", {19'd0, char_y, char_x}, 32'd0);
    check("post_cur", {19'd0, cur_y, cur_x}, {19'd0, 6'd0, 7'd1});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
